// File: rtl/pwm_detection_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_detection_mc
//  Purpose  : Multi-channel PWM high/low time detector. Each channel
//             synchronises and glitch-filters its pin, measures the high and
//             low phase lengths in clk cycles, captures completed phases and
//             pulses a one-cycle interrupt per capture. Saturation and
//             stuck-signal (timeout) flags are reported per channel.
//  Ports    : clk            - system clock
//             reset          - asynchronous active-high reset
//             enable         - global measurement enable
//             pwm_in         - raw PWM pins (asynchronous), one per channel
//             count_high_pwm - captured high time, ch i at [i*CNT_W +: CNT_W]
//             count_low_pwm  - captured low time, same packing
//             hready_intr    - one-cycle pulse, new high count captured
//             lready_intr    - one-cycle pulse, new low count captured
//             sat            - last capture on the channel saturated
//             stuck          - current phase has reached TIMEOUT_CYC
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_detection_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       pwm_in,
  output logic [NUM_CH*CNT_W-1:0] count_high_pwm,
  output logic [NUM_CH*CNT_W-1:0] count_low_pwm,
  output logic [NUM_CH-1:0]       hready_intr,
  output logic [NUM_CH-1:0]       lready_intr,
  output logic [NUM_CH-1:0]       sat,
  output logic [NUM_CH-1:0]       stuck
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TO  = CNT_W'(TIMEOUT_CYC);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_lvl;
    logic                   f_lvl;
    logic                   f_d_q;
    logic                   rise;
    logic                   fall;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] run_h_q,  run_h_d;
    logic [CNT_W-1:0] run_l_q,  run_l_d;
    logic [CNT_W-1:0] cap_h_q,  cap_h_d;
    logic [CNT_W-1:0] cap_l_q,  cap_l_d;
    logic             hintr_q,  hintr_d;
    logic             lintr_q,  lintr_d;
    logic             sat_q,    sat_d;
    logic             stuck_q,  stuck_d;

    // Input synchroniser; the pin is asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in[i]};
      end
    end

    assign s_lvl = sync_q[SYNC_STAGES-1];

    if (FILTER_CYC == 0) begin : g_bypass
      assign f_lvl = s_lvl;
    end else begin : g_filter
      localparam int             FW         = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
      localparam logic [FW-1:0]  C_FLT_LAST = FW'(FILTER_CYC - 1);

      logic [FW-1:0] filt_cnt_q;
      logic          f_q;

      // The filtered level only follows s after FILTER_CYC consecutive
      // cycles of disagreement; both edges see the same delay so phase
      // widths pass through unchanged.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          filt_cnt_q <= '0;
          f_q        <= 1'b0;
        end else if (s_lvl == f_q) begin
          filt_cnt_q <= '0;
        end else if (filt_cnt_q == C_FLT_LAST) begin
          filt_cnt_q <= '0;
          f_q        <= s_lvl;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end

      assign f_lvl = f_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        f_d_q <= 1'b0;
      end else begin
        f_d_q <= f_lvl;
      end
    end

    assign rise = f_lvl & ~f_d_q;
    assign fall = ~f_lvl & f_d_q;

    always_comb begin
      state_d = state_q;
      run_h_d = run_h_q;
      run_l_d = run_l_q;
      cap_h_d = cap_h_q;
      cap_l_d = cap_l_q;
      hintr_d = 1'b0;
      lintr_d = 1'b0;
      sat_d   = sat_q;
      stuck_d = stuck_q;

      if (!enable) begin
        state_d = ST_IDLE;
        run_h_d = '0;
        run_l_d = '0;
        stuck_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            run_h_d = '0;
            run_l_d = '0;
            if (rise) begin
              state_d = ST_HIGH;
              run_h_d = C_ONE;
            end else if (fall) begin
              state_d = ST_LOW;
              run_l_d = C_ONE;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              // run_h already includes the last high cycle here.
              cap_h_d = run_h_q;
              sat_d   = (run_h_q == C_MAX);
              hintr_d = 1'b1;
              stuck_d = 1'b0;
              run_h_d = '0;
              run_l_d = C_ONE;
              state_d = ST_LOW;
            end else if (run_h_q != C_MAX) begin
              run_h_d = run_h_q + C_ONE;
            end
          end
          ST_LOW: begin
            if (rise) begin
              cap_l_d = run_l_q;
              sat_d   = (run_l_q == C_MAX);
              lintr_d = 1'b1;
              stuck_d = 1'b0;
              run_l_d = '0;
              run_h_d = C_ONE;
              state_d = ST_HIGH;
            end else if (run_l_q != C_MAX) begin
              run_l_d = run_l_q + C_ONE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            run_h_d = '0;
            run_l_d = '0;
          end
        endcase

        // Compare against the next counter value so stuck rises on the
        // same edge the active counter reaches TIMEOUT_CYC.
        if (TIMEOUT_CYC > 0) begin
          if (((state_d == ST_HIGH) && (run_h_d == C_TO)) ||
              ((state_d == ST_LOW)  && (run_l_d == C_TO))) begin
            stuck_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        run_h_q <= '0;
        run_l_q <= '0;
        cap_h_q <= '0;
        cap_l_q <= '0;
        hintr_q <= 1'b0;
        lintr_q <= 1'b0;
        sat_q   <= 1'b0;
        stuck_q <= 1'b0;
      end else begin
        state_q <= state_d;
        run_h_q <= run_h_d;
        run_l_q <= run_l_d;
        cap_h_q <= cap_h_d;
        cap_l_q <= cap_l_d;
        hintr_q <= hintr_d;
        lintr_q <= lintr_d;
        sat_q   <= sat_d;
        stuck_q <= stuck_d;
      end
    end

    assign count_high_pwm[i*CNT_W +: CNT_W] = cap_h_q;
    assign count_low_pwm[i*CNT_W +: CNT_W]  = cap_l_q;
    assign hready_intr[i]                   = hintr_q;
    assign lready_intr[i]                   = lintr_q;
    assign sat[i]                           = sat_q;
    assign stuck[i]                         = stuck_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_detection_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pwm_detection_mc
//  Purpose  : Directed self-checking bench for pwm_detection_mc
//             (NUM_CH=4, CNT_W=8, FILTER_CYC=2, TIMEOUT_CYC=100).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_detection_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [NUM_CH-1:0]       pin;
  logic [NUM_CH*CNT_W-1:0] count_high_pwm;
  logic [NUM_CH*CNT_W-1:0] count_low_pwm;
  logic [NUM_CH-1:0]       hready_intr;
  logic [NUM_CH-1:0]       lready_intr;
  logic [NUM_CH-1:0]       sat;
  logic [NUM_CH-1:0]       stuck;

  int vectors     = 0;
  int miscompares = 0;
  int hcnt [NUM_CH];
  int lcnt [NUM_CH];
  int both_cnt = 0;

  pwm_detection_mc #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .FILTER_CYC  (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .pwm_in         (pin),
    .count_high_pwm (count_high_pwm),
    .count_low_pwm  (count_low_pwm),
    .hready_intr    (hready_intr),
    .lready_intr    (lready_intr),
    .sat            (sat),
    .stuck          (stuck)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge.
  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      hcnt[i] = 0;
      lcnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (hready_intr[i]) hcnt[i] = hcnt[i] + 1;
      if (lready_intr[i]) lcnt[i] = lcnt[i] + 1;
    end
    if ((hready_intr & lready_intr) != '0) both_cnt = both_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hi(input int ch);
    return 32'(count_high_pwm[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [31:0] lo(input int ch);
    return 32'(count_low_pwm[ch*CNT_W +: CNT_W]);
  endfunction

  int base_h;
  int base_l;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pin    = '0;
    cyc(3);
    check("rst_count_high", count_high_pwm, 32'd0);
    check("rst_count_low",  count_low_pwm,  32'd0);
    check("rst_flags", {16'd0, hready_intr, lready_intr, sat, stuck}, 32'd0);
    reset  = 1'b0;
    enable = 1'b1;
    cyc(5);

    // ch0: 10 high / 30 low, three periods, first fall timed exactly.
    pin[0] = 1'b1; cyc(10);
    pin[0] = 1'b0; cyc(4);
    check("ch0_hready_early", 32'(hready_intr[0]), 32'd0);
    cyc(1);
    check("ch0_hready_on_time", 32'(hready_intr[0]), 32'd1);
    check("ch0_high_first", hi(0), 32'd10);
    cyc(1);
    check("ch0_hready_one_cycle", 32'(hready_intr[0]), 32'd0);
    cyc(24);
    for (int p = 0; p < 2; p++) begin
      pin[0] = 1'b1; cyc(10);
      pin[0] = 1'b0; cyc(30);
    end
    pin[0] = 1'b1; cyc(10);
    check("ch0_high", hi(0), 32'd10);
    check("ch0_low",  lo(0), 32'd30);
    check("ch0_hready_count", 32'(hcnt[0]), 32'd3);
    check("ch0_lready_count", 32'(lcnt[0]), 32'd3);
    check("others_high_zero", {count_high_pwm[31:8], 8'd0}, 32'd0);
    check("others_low_zero",  {count_low_pwm[31:8], 8'd0},  32'd0);
    pin[0] = 1'b0; cyc(10);

    // ch1: enter LOW, then 1-cycle glitch (filtered) and 2-cycle glitch.
    pin[1] = 1'b1; cyc(5);
    pin[1] = 1'b0; cyc(20);
    pin[1] = 1'b1; cyc(1);
    pin[1] = 1'b0; cyc(20);
    check("ch1_glitch1_no_h", 32'(hcnt[1]), 32'd1);
    check("ch1_glitch1_no_l", 32'(lcnt[1]), 32'd0);
    pin[1] = 1'b1; cyc(2);
    pin[1] = 1'b0; cyc(10);
    check("ch1_low_through_glitch", lo(1), 32'd41);
    check("ch1_glitch2_high", hi(1), 32'd2);
    check("ch1_hready_count", 32'(hcnt[1]), 32'd2);
    check("ch1_lready_count", 32'(lcnt[1]), 32'd1);

    // ch2: 300-cycle high saturates an 8-bit counter, then 50 clears sat.
    pin[2] = 1'b1; cyc(300);
    pin[2] = 1'b0; cyc(8);
    check("ch2_sat_value", hi(2), 32'd255);
    check("ch2_sat_flag", 32'(sat[2]), 32'd1);
    check("ch2_stuck_cleared", 32'(stuck[2]), 32'd0);
    pin[2] = 1'b1; cyc(50);
    pin[2] = 1'b0; cyc(8);
    check("ch2_high_50", hi(2), 32'd50);
    check("ch2_sat_clear", 32'(sat[2]), 32'd0);

    // ch3: 150-cycle low phase, stuck rises exactly when run_l hits 100.
    pin[3] = 1'b1; cyc(5);
    pin[3] = 1'b0; cyc(103);
    check("ch3_stuck_before", 32'(stuck[3]), 32'd0);
    cyc(1);
    check("ch3_stuck_at_100", 32'(stuck[3]), 32'd1);
    cyc(46);
    check("ch3_stuck_holds", 32'(stuck[3]), 32'd1);
    pin[3] = 1'b1; cyc(4);
    check("ch3_stuck_until_capture", 32'(stuck[3]), 32'd1);
    cyc(1);
    check("ch3_stuck_clear", 32'(stuck[3]), 32'd0);
    check("ch3_low_150", lo(3), 32'd150);
    check("ch3_lready", 32'(lready_intr[3]), 32'd1);

    // ch0 and ch1 driven together.
    pin[1:0] = 2'b11; cyc(5);
    check("ch01_lready_simul", 32'(lready_intr[1:0]), 32'd3);
    check("ch0_low_saturated", lo(0), 32'd255);
    check("ch0_stuck_clear", 32'(stuck[0]), 32'd0);
    cyc(7);
    pin[1:0] = 2'b00; cyc(5);
    check("ch01_hready_simul", 32'(hready_intr[1:0]), 32'd3);
    check("ch0_high_12", hi(0), 32'd12);
    check("ch1_high_12", hi(1), 32'd12);
    cyc(10);

    // Asynchronous reset in the middle of a high phase on ch0.
    pin[0] = 1'b1; cyc(20);
    reset = 1'b1; #1;
    check("async_rst_high", count_high_pwm, 32'd0);
    check("async_rst_low",  count_low_pwm,  32'd0);
    check("async_rst_flags", {16'd0, hready_intr, lready_intr, sat, stuck}, 32'd0);
    cyc(2);
    reset  = 1'b0;
    base_h = hcnt[0] + hcnt[1] + hcnt[2] + hcnt[3];
    base_l = lcnt[0] + lcnt[1] + lcnt[2] + lcnt[3];
    cyc(10);
    check("post_rst_no_hready", 32'(hcnt[0] + hcnt[1] + hcnt[2] + hcnt[3]), 32'(base_h));
    check("post_rst_no_lready", 32'(lcnt[0] + lcnt[1] + lcnt[2] + lcnt[3]), 32'(base_l));
    pin[0] = 1'b0; cyc(10);
    pin[0] = 1'b1; cyc(7);
    pin[0] = 1'b0; cyc(10);
    check("ch0_high_7", hi(0), 32'd7);

    // Disable for 20 cycles mid-phase; the pin falls while disabled.
    pin[0] = 1'b1; cyc(10);
    base_h = hcnt[0];
    base_l = lcnt[0];
    enable = 1'b0; cyc(5);
    pin[0] = 1'b0; cyc(15);
    check("dis_capture_held", hi(0), 32'd7);
    check("dis_no_hready", 32'(hcnt[0]), 32'(base_h));
    check("dis_no_lready", 32'(lcnt[0]), 32'(base_l));
    check("dis_stuck_clear", 32'(stuck), 32'd0);
    enable = 1'b1; cyc(3);
    pin[0] = 1'b1; cyc(15);
    pin[0] = 1'b0; cyc(6);
    check("reen_full_phase", hi(0), 32'd15);
    check("reen_one_hready", 32'(hcnt[0]), 32'(base_h + 1));
    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
